// File: rtl/pdp8_uart_pkg.sv
// -----------------------------------------------------------------------------
// pdp8_uart_pkg
// Shared definitions for the PDP-8 console UART core: default frame geometry,
// the serial idle level and the state encodings of the TX and RX FSMs.
// No ports; imported by the interface, the receiver and the top level.
// -----------------------------------------------------------------------------
package pdp8_uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_LOAD  = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/pdp8_tt_uart_if.sv
// -----------------------------------------------------------------------------
// pdp8_tt_uart_if
// Parallel side of the console UART: the TX and RX req/ack handshakes plus
// status towards the TT device.
//   master : TT device side (drives tx_req, tx_data, rx_req)
//   slave  : UART core side (drives acks, rx_data and status flags)
// -----------------------------------------------------------------------------
interface pdp8_tt_uart_if;
    import pdp8_uart_pkg::*;

    logic                 tx_req;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ack;
    logic                 tx_empty;
    logic                 rx_req;
    logic                 rx_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic                 rx_overrun;
    logic                 rx_frame_err;

    modport master (
        output tx_req, tx_data, rx_req,
        input  tx_ack, tx_empty, rx_ack, rx_data, rx_empty, rx_overrun, rx_frame_err
    );

    modport slave (
        input  tx_req, tx_data, rx_req,
        output tx_ack, tx_empty, rx_ack, rx_data, rx_empty, rx_overrun, rx_frame_err
    );

endinterface

// File: rtl/pdp8_uart_rx.sv
// -----------------------------------------------------------------------------
// pdp8_uart_rx
// Serial receiver: 2-FF synchroniser on rxd, oversampled start/data/stop FSM
// and LSB-first shifter. All timing advances on rx_baud_en only.
//   clk, reset_n  : clock, async active-low reset
//   rx_baud_en    : OVERSAMPLE strobes per bit period
//   rxd           : asynchronous serial input
//   byte_valid    : one-clk, high in the clk whose edge samples a good stop bit
//   byte_data     : assembled character (valid with byte_valid)
//   frame_err     : registered one-clk pulse after a stop bit sampled 0
// -----------------------------------------------------------------------------
module pdp8_uart_rx #(
    parameter int DATA_BITS  = pdp8_uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = pdp8_uart_pkg::OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_baud_en,
    input  logic                 rxd,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 frame_err
);
    import pdp8_uart_pkg::*;

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic [1:0]           sync_q, sync_d;
    rx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 commit_s;
    logic                 rxd_s;

    assign rxd_s      = sync_q[1];
    assign byte_valid = commit_s;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

    // Synchroniser, FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= {2{IDLE_LEVEL}};
            state_q     <= RX_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: start validation at half a bit, then sample each bit centre.
    always_comb begin
        sync_d      = {sync_q[0], rxd};
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        commit_s    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_baud_en && (rxd_s == 1'b0)) begin
                    state_d = RX_START;
                    tick_d  = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_baud_en) begin
                    if (tick_q == HALF_TICK) begin
                        // Line back high at mid start bit: treat as a glitch.
                        state_d = rxd_s ? RX_IDLE : RX_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_baud_en) begin
                    tick_d = tick_q + TICK_W'(1);
                    if (tick_q == LAST_TICK) begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
                            state_d = RX_STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_baud_en) begin
                    tick_d = tick_q + TICK_W'(1);
                    if (tick_q == LAST_TICK) begin
                        // Leave at stop-bit centre so an immediate next start edge is seen.
                        state_d = RX_IDLE;
                        if (rxd_s) begin
                            commit_s = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        state_d = RX_STOP;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            default: begin
                state_d = RX_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pdp8_tt_uart.sv
// -----------------------------------------------------------------------------
// pdp8_tt_uart
// Console UART core for the PDP-8 TT device. TX FSM and both req/ack
// handshakes live here; the serial receiver is pdp8_uart_rx.
//   clk, reset_n             : clock, async active-low reset
//   tx_baud_en / rx_baud_en  : baud strobes from the BRG (1x TX, OVERSAMPLE x RX)
//   txd / rxd                : serial pins, idle high
//   bus (slave)              : tx_req/tx_data/tx_ack/tx_empty,
//                              rx_req/rx_ack/rx_data/rx_empty/rx_overrun/rx_frame_err
// -----------------------------------------------------------------------------
module pdp8_tt_uart #(
    parameter int DATA_BITS  = pdp8_uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = pdp8_uart_pkg::OVERSAMPLE
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tx_baud_en,
    input  logic          rx_baud_en,
    input  logic          rxd,
    output logic          txd,
    pdp8_tt_uart_if.slave bus
);
    import pdp8_uart_pkg::*;

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    // ---------------- TX ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic                 txd_q, txd_d;
    logic                 tx_ack_q, tx_ack_d;
    logic                 tx_empty_q, tx_empty_d;
    logic                 tx_stop_done_q, tx_stop_done_d;

    // TX FSM and handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q     <= TX_IDLE;
            tx_shift_q     <= '0;
            tx_bit_q       <= '0;
            txd_q          <= IDLE_LEVEL;
            tx_ack_q       <= 1'b0;
            tx_empty_q     <= 1'b1;
            tx_stop_done_q <= 1'b0;
        end else begin
            tx_state_q     <= tx_state_d;
            tx_shift_q     <= tx_shift_d;
            tx_bit_q       <= tx_bit_d;
            txd_q          <= txd_d;
            tx_ack_q       <= tx_ack_d;
            tx_empty_q     <= tx_empty_d;
            tx_stop_done_q <= tx_stop_done_d;
        end
    end

    // TX next state: accept, then one line change per tx_baud_en.
    always_comb begin
        tx_state_d     = tx_state_q;
        tx_shift_d     = tx_shift_q;
        tx_bit_d       = tx_bit_q;
        txd_d          = txd_q;
        tx_empty_d     = tx_empty_q;
        tx_stop_done_d = tx_stop_done_q;
        // Ack is held exactly as long as the request.
        tx_ack_d       = tx_ack_q ? bus.tx_req : 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.tx_req && tx_empty_q && !tx_ack_q) begin
                    tx_shift_d = bus.tx_data;
                    tx_ack_d   = 1'b1;
                    tx_empty_d = 1'b0;
                    tx_state_d = TX_LOAD;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_LOAD: begin
                if (tx_baud_en) begin
                    txd_d      = 1'b0;
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_LOAD;
                end
            end
            TX_START: begin
                if (tx_baud_en) begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_baud_en) begin
                    if (tx_bit_q == LAST_BIT) begin
                        txd_d          = IDLE_LEVEL;
                        tx_stop_done_d = 1'b0;
                        tx_state_d     = TX_STOP;
                    end else begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                    end
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_STOP: begin
                // A still-asserted ack holds off empty so TT always sees ack first.
                if ((tx_baud_en || tx_stop_done_q) && !tx_ack_q) begin
                    tx_empty_d     = 1'b1;
                    tx_stop_done_d = 1'b0;
                    tx_state_d     = TX_IDLE;
                end else if (tx_baud_en) begin
                    tx_stop_done_d = 1'b1;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = IDLE_LEVEL;
                tx_empty_d = 1'b1;
            end
        endcase
    end

    assign txd          = txd_q;
    assign bus.tx_ack   = tx_ack_q;
    assign bus.tx_empty = tx_empty_q;

    // ---------------- RX ----------------
    logic                 rx_commit_s;
    logic [DATA_BITS-1:0] rx_byte_s;
    logic                 rx_grant_s;
    logic                 rx_ack_q, rx_ack_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_empty_q, rx_empty_d;
    logic                 rx_overrun_q, rx_overrun_d;

    pdp8_uart_rx #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_baud_en (rx_baud_en),
        .rxd        (rxd),
        .byte_valid (rx_commit_s),
        .byte_data  (rx_byte_s),
        .frame_err  (bus.rx_frame_err)
    );

    // RX holding register and handshake state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ack_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_empty_q   <= 1'b1;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_ack_q     <= rx_ack_d;
            rx_data_q    <= rx_data_d;
            rx_empty_q   <= rx_empty_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    // A commit pre-empts a grant in the same clk; the grant retries next clk on the new byte.
    always_comb begin
        rx_grant_s = bus.rx_req && !rx_empty_q && !rx_ack_q && !rx_commit_s;
        rx_ack_d   = rx_ack_q ? bus.rx_req : rx_grant_s;
        if (rx_commit_s) begin
            rx_data_d    = rx_byte_s;
            rx_empty_d   = 1'b0;
            rx_overrun_d = rx_overrun_q | !rx_empty_q;
        end else if (rx_grant_s) begin
            rx_data_d    = rx_data_q;
            rx_empty_d   = 1'b1;
            rx_overrun_d = 1'b0;
        end else begin
            rx_data_d    = rx_data_q;
            rx_empty_d   = rx_empty_q;
            rx_overrun_d = rx_overrun_q;
        end
    end

    assign bus.rx_ack     = rx_ack_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_empty   = rx_empty_q;
    assign bus.rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_pdp8_tt_uart.sv
// -----------------------------------------------------------------------------
// tb_pdp8_tt_uart
// Directed + randomised bench for pdp8_tt_uart. TX frames are checked against
// the 8N1 bit pattern built from the byte; RX is checked against a small model
// of the holding register (data, empty, overrun, frame-error count).
// -----------------------------------------------------------------------------
module tb_pdp8_tt_uart;
    import pdp8_uart_pkg::*;

    localparam int TX_DIV   = 20;
    localparam int RX_DIV   = 4;
    localparam int BIT_CLKS = RX_DIV * OVERSAMPLE;

    logic clk        = 1'b0;
    logic reset_n    = 1'b0;
    logic tx_baud_en = 1'b0;
    logic rx_baud_en = 1'b0;
    logic rxd        = 1'b1;
    logic txd;

    int total = 0;
    int bad   = 0;
    int tx_div_cnt = 0;
    int rx_div_cnt = 0;
    int fe_cnt = 0;

    // RX reference model
    logic [7:0] m_data  = 8'h00;
    logic       m_empty = 1'b1;
    logic       m_ovr   = 1'b0;
    int         fe_exp  = 0;

    pdp8_tt_uart_if bus ();

    pdp8_tt_uart dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_baud_en (tx_baud_en),
        .rx_baud_en (rx_baud_en),
        .rxd        (rxd),
        .txd        (txd),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Baud strobes change on the falling edge so they are stable at the rising edge.
    always @(negedge clk) begin
        tx_div_cnt = (tx_div_cnt + 1) % TX_DIV;
        rx_div_cnt = (rx_div_cnt + 1) % RX_DIV;
        tx_baud_en = (tx_div_cnt == 0);
        rx_baud_en = (rx_div_cnt == 0);
    end

    // Count clocks in which the frame-error pulse is high.
    always @(posedge clk) begin
        if (bus.rx_frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // After tx_ack: drop tx_req, then check the 10 line levels and empty after stop.
    task automatic tx_collect(input logic [7:0] b);
        logic [9:0] frame;
        logic       baud;
        int         n;
        frame = {1'b1, b, 1'b0};
        n = 0;
        for (int c = 0; (c < 14 * TX_DIV) && (n < 11); c++) begin
            @(negedge clk);
            if (c == 0) bus.tx_req = 1'b0;
            @(posedge clk);
            baud = tx_baud_en;
            #1;
            if (c == 0) chk("tx_ack_fall", 32'(bus.tx_ack), 32'd0);
            if (baud) begin
                if (n < 10) chk($sformatf("txd_bit%0d_of_%02h", n, b), 32'(txd), 32'(frame[n]));
                if (n == 9) chk("tx_empty_in_stop", 32'(bus.tx_empty), 32'd0);
                if (n == 10) chk("tx_empty_after_stop", 32'(bus.tx_empty), 32'd1);
                n++;
            end
        end
        chk("tx_frame_len", 32'(n), 32'd11);
    endtask

    task automatic tx_frame(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_req  = 1'b1;
        for (int i = 0; i < 4 * TX_DIV; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_ack) break;
        end
        chk("tx_ack_rise", 32'(bus.tx_ack), 32'd1);
        chk("tx_empty_on_accept", 32'(bus.tx_empty), 32'd0);
        tx_collect(b);
    endtask

    task automatic wait_tx_bauds(input int k);
        int n;
        n = 0;
        for (int c = 0; (c < (k + 1) * TX_DIV) && (n < k); c++) begin
            @(posedge clk);
            if (tx_baud_en) n++;
        end
    endtask

    // Drive one serial frame on rxd and update the reference model.
    task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (stop_ok ? BIT_CLKS : (BIT_CLKS * 3) / 4) @(negedge clk);
        rxd = 1'b1;
        if (!stop_ok) repeat (2 * BIT_CLKS) @(negedge clk);
        if (stop_ok) begin
            if (!m_empty) m_ovr = 1'b1;
            m_data  = b;
            m_empty = 1'b0;
        end else begin
            fe_exp++;
        end
        chk($sformatf("rx_data_after_%02h", b), 32'(bus.rx_data), 32'(m_data));
        chk("rx_empty_after_frame", 32'(bus.rx_empty), 32'(m_empty));
        chk("rx_overrun_after_frame", 32'(bus.rx_overrun), 32'(m_ovr));
        chk("rx_frame_err_pulses", 32'(fe_cnt), 32'(fe_exp));
    endtask

    task automatic rx_take();
        @(negedge clk);
        bus.rx_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.rx_ack) break;
        end
        chk("rx_ack_rise", 32'(bus.rx_ack), 32'd1);
        chk("rx_data_at_ack", 32'(bus.rx_data), 32'(m_data));
        chk("rx_empty_at_ack", 32'(bus.rx_empty), 32'd1);
        chk("rx_overrun_at_ack", 32'(bus.rx_overrun), 32'd0);
        m_empty = 1'b1;
        m_ovr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rx_ack_hold", 32'(bus.rx_ack), 32'd1);
        @(negedge clk);
        bus.rx_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rx_ack_fall", 32'(bus.rx_ack), 32'd0);
    endtask

    initial begin
        logic [7:0] b1;
        logic [7:0] b2;
        logic       prev_empty;

        bus.tx_req  = 1'b0;
        bus.tx_data = 8'h00;
        bus.rx_req  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_tx_ack", 32'(bus.tx_ack), 32'd0);
        chk("rst_tx_empty", 32'(bus.tx_empty), 32'd1);
        chk("rst_rx_ack", 32'(bus.rx_ack), 32'd0);
        chk("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_rx_overrun", 32'(bus.rx_overrun), 32'd0);
        chk("rst_rx_frame_err", 32'(bus.rx_frame_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // TX: directed 0x41 then random bytes
        tx_frame(8'h41);
        for (int k = 0; k < 3; k++) tx_frame(8'($urandom));

        // TX busy: second request mid-frame is held off until empty
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        @(negedge clk);
        bus.tx_data = b1;
        bus.tx_req  = 1'b1;
        for (int i = 0; i < 4 * TX_DIV; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_ack) break;
        end
        chk("busy_first_ack", 32'(bus.tx_ack), 32'd1);
        @(negedge clk);
        bus.tx_req = 1'b0;
        wait_tx_bauds(3);
        @(negedge clk);
        bus.tx_data = b2;
        bus.tx_req  = 1'b1;
        prev_empty  = 1'b0;
        for (int i = 0; i < 20 * TX_DIV; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_ack) break;
            prev_empty = bus.tx_empty;
        end
        chk("busy_second_ack", 32'(bus.tx_ack), 32'd1);
        chk("busy_empty_before_ack", 32'(prev_empty), 32'd1);
        chk("busy_empty_on_accept", 32'(bus.tx_empty), 32'd0);
        tx_collect(b2);

        // Async reset in the middle of a TX frame of 0x00
        @(negedge clk);
        bus.tx_data = 8'h00;
        bus.tx_req  = 1'b1;
        for (int i = 0; i < 4 * TX_DIV; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_ack) break;
        end
        @(negedge clk);
        bus.tx_req = 1'b0;
        wait_tx_bauds(4);
        @(posedge clk);
        #3;
        chk("pre_reset_txd", 32'(txd), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_txd", 32'(txd), 32'd1);
        chk("async_rst_tx_empty", 32'(bus.tx_empty), 32'd1);
        chk("async_rst_tx_ack", 32'(bus.tx_ack), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // RX 0x55 and handshake
        rx_frame(8'h55, 1'b1);
        rx_take();

        // rx_req with nothing held is ignored
        @(negedge clk);
        bus.rx_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rx_req_empty_ignored", 32'(bus.rx_ack), 32'd0);
        @(negedge clk);
        bus.rx_req = 1'b0;

        // Overrun: two frames back to back without a handshake
        rx_frame(8'h12, 1'b1);
        rx_frame(8'h34, 1'b1);
        rx_take();

        // Short low glitch on rxd: no byte, no error
        @(negedge clk);
        rxd = 1'b0;
        repeat (4 * RX_DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("glitch_no_frame_err", 32'(fe_cnt), 32'(fe_exp));
        chk("glitch_rx_empty", 32'(bus.rx_empty), 32'(m_empty));

        // Bad stop bit: one error pulse, byte discarded
        rx_frame(8'hA7, 1'b0);

        // Random RX traffic against the model
        for (int k = 0; k < 6; k++) begin
            rx_frame(8'($urandom), ($urandom_range(3) != 0));
            if (!m_empty && ($urandom_range(1) == 1)) rx_take();
        end
        if (!m_empty) rx_take();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
